// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one backing memory port between instruction fetch (imem) and the
//   MEM/WB data path (dmem). Each requester sends one-cycle mask pulses. A
//   pulse is captured into that requester's pending register. From IDLE the
//   arbiter issues one pending request on mem_* for a single cycle. It then
//   waits for mem_resp and routes the response to the requester that owns
//   the transaction.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   imem_addr/rmask -> imem_rdata/resp    fetch request / response
//   dmem_addr/rmask/wmask/wdata -> dmem_rdata/resp   data request / response
//   mem_addr/rmask/wmask/wdata -> mem_rdata/resp     backing memory port
//
// Build option
//   MEM_ARB_RR_EN : when defined, a tie between the requesters goes to the
//                   one that was not granted last. The tracking register
//                   resets to imem, so the first tie goes to dmem. When not
//                   defined, dmem always wins over imem.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_I = 2'd1;
    localparam logic [1:0] WAIT_D = 2'd2;

    logic [1:0]  state, state_nxt;

    logic        i_vld;
    logic [31:0] i_addr;
    logic [3:0]  i_rmask;

    logic        d_vld;
    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;

    logic        i_req, d_req;
    logic        i_busy, d_busy;
    logic        i_take, d_take;
    logic        grant_i, grant_d;

    assign i_req = |imem_rmask;
    assign d_req = (|dmem_rmask) || (|dmem_wmask);

    // A requester stays busy until its resp cycle. In the resp cycle it may
    // already send its next request.
    assign i_busy = i_vld || ((state == WAIT_I) && !mem_resp);
    assign d_busy = d_vld || ((state == WAIT_D) && !mem_resp);

    // A request that arrives while the requester is busy is dropped, so the
    // stored copy is left unchanged.
    assign i_take = i_req && !i_busy;
    assign d_take = d_req && !d_busy;

    // A grant lasts only the single issue cycle. Gating it with rst keeps
    // mem_* at zero while reset is held.
`ifdef MEM_ARB_RR_EN
    logic last_d;   // 1: the most recent grant went to dmem

    always_ff @(posedge clk) begin
        if (rst)
            last_d <= 1'b0;
        else if (grant_i || grant_d)
            last_d <= grant_d;
    end

    assign grant_d = !rst && (state == IDLE) && d_vld && (!i_vld || !last_d);
`else
    assign grant_d = !rst && (state == IDLE) && d_vld;
`endif
    assign grant_i = !rst && (state == IDLE) && i_vld && !grant_d;

    // Pending registers. A grant (which needs vld=1) and a capture (which
    // needs vld=0) never happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_vld   <= 1'b0;
            i_addr  <= '0;
            i_rmask <= '0;
            d_vld   <= 1'b0;
            d_addr  <= '0;
            d_rmask <= '0;
            d_wmask <= '0;
            d_wdata <= '0;
        end else begin
            if (grant_i) begin
                i_vld <= 1'b0;
            end else if (i_take) begin
                i_vld   <= 1'b1;
                i_addr  <= imem_addr;
                i_rmask <= imem_rmask;
            end
            if (grant_d) begin
                d_vld <= 1'b0;
            end else if (d_take) begin
                d_vld   <= 1'b1;
                d_addr  <= dmem_addr;
                d_rmask <= dmem_rmask;
                d_wmask <= dmem_wmask;
                d_wdata <= dmem_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)
                    state_nxt = WAIT_D;
                else if (grant_i)
                    state_nxt = WAIT_I;
            end
            WAIT_I, WAIT_D: begin
                if (mem_resp)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Memory side: driven only in the issue cycle, otherwise all zero.
    always_comb begin
        mem_addr  = '0;
        mem_rmask = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_addr  = d_addr;
            mem_rmask = d_rmask;
            mem_wmask = d_wmask;
            mem_wdata = d_wdata;
        end else if (grant_i) begin
            mem_addr  = i_addr;
            mem_rmask = i_rmask;
        end
    end

    // The response passes straight through to the owner in the same cycle.
    // A mem_resp seen in IDLE (a stray one) produces nothing.
    assign imem_resp  = !rst && (state == WAIT_I) && mem_resp;
    assign dmem_resp  = !rst && (state == WAIT_D) && mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : '0;
    assign dmem_rdata = dmem_resp ? mem_rdata : '0;

`ifndef SYNTHESIS
    // Protocol violations are reported but do not stop the run. The
    // arbiter's behaviour when a violation is ignored must stay observable.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!((|dmem_rmask) && (|dmem_wmask)))
                else $warning("mem_port_arbiter: dmem read and write in one cycle");
            assert (!(i_req && i_busy))
                else $warning("mem_port_arbiter: imem request while busy ignored");
            assert (!(d_req && d_busy))
                else $warning("mem_port_arbiter: dmem request while busy ignored");
            assert (!(mem_resp && (state == IDLE)))
                else $warning("mem_port_arbiter: stray mem_resp in IDLE ignored");
        end
    end
`endif

endmodule
